farm_sensor_cond: RTL

- Conditions the farm-road vehicle loop detector and the pedestrian push-button into the single registered request `c` consumed by the `Traffic_light` controller.
- Takes the controller's `FG` output back as `fg`, so a request is held until it has been served.
- Sits directly upstream of the controller in the intersection top level.

---
 rtl/traffic_pkg.sv | 27 ++
 rtl/sensor_debounce.sv | 56 +++++
 rtl/farm_sensor_cond.sv | 136 +++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the intersection controller slice.
//   state_t       : farm-road request FSM encoding (IDLE/REQ/SERVE/DRAIN)
//   DEF_DEB_CYC   : default debounce length for the vehicle loop
//   DEF_HOLD_CYC  : default request hold after the vehicle leaves
//   cnt_width()   : width that holds the larger of two counter bounds
// ---------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        SERVE = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int DEF_DEB_CYC  = 4;
    localparam int DEF_HOLD_CYC = 3;

    // Both counters share one width so they can be compared and loaded
    // without casts between differently sized vectors.
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// ---------------------------------------------------------------------------
// sensor_debounce
// Two-flop synchronizer followed by a stable-sample debounce counter.
// The debounced level only changes after DEB_CYC consecutive synced samples
// that disagree with it; any agreement in between restarts the count.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   raw  : asynchronous, possibly bouncing input level
//   db   : debounced level
// ---------------------------------------------------------------------------
module sensor_debounce
    import traffic_pkg::*;
#(
    parameter int DEB_CYC = DEF_DEB_CYC,
    parameter int CNT_W   = cnt_width(DEF_DEB_CYC, DEF_HOLD_CYC)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db
);

    logic             meta;
    logic             sync;
    logic [CNT_W-1:0] deb_cnt;

    // Two-stage synchronizer: the first flop may go metastable, the second
    // presents a clean level to the debounce counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // Count consecutive disagreements between the synced sample and the
    // debounced level. The count never passes DEB_CYC-1: reaching it commits
    // the new level and the count returns to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db      <= 1'b0;
            deb_cnt <= '0;
        end else if (sync == db) begin
            deb_cnt <= '0;
        end else if (deb_cnt == CNT_W'(DEB_CYC - 1)) begin
            db      <= sync;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/farm_sensor_cond.sv
// ---------------------------------------------------------------------------
// farm_sensor_cond
// Conditions the farm-road vehicle loop and pedestrian button into the
// single registered request c for the traffic light controller. The
// controller's farm green is fed back as fg so a request is held until it
// has actually been served.
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset
//   car_raw  : loop detector level (asynchronous, may bounce)
//   ped_btn  : pedestrian button level (asynchronous)
//   fg       : farm-road green from the controller
//   c        : farm-road request, decoded from the state register
//   car_db   : debounced vehicle presence
//   ped_pend : pedestrian request latched and not yet served
// ---------------------------------------------------------------------------
module farm_sensor_cond
    import traffic_pkg::*;
#(
    parameter int DEB_CYC  = DEF_DEB_CYC,
    parameter int HOLD_CYC = DEF_HOLD_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic car_raw,
    input  logic ped_btn,
    input  logic fg,
    output logic c,
    output logic car_db,
    output logic ped_pend
);

    localparam int CNT_W = cnt_width(DEB_CYC, HOLD_CYC);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] hold_cnt;
    logic             ped_meta;
    logic             ped_s;
    logic             ped_d;
    logic             ped_rise;
    logic             enter_serve;

    sensor_debounce #(
        .DEB_CYC (DEB_CYC),
        .CNT_W   (CNT_W)
    ) u_car_debounce (
        .clk (clk),
        .rst (rst),
        .raw (car_raw),
        .db  (car_db)
    );

    // The button is a clean press, so it only needs synchronizing. A third
    // flop keeps the previous synced level for edge detection, which is what
    // makes a held button count as a single request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_meta <= 1'b0;
            ped_s    <= 1'b0;
            ped_d    <= 1'b0;
        end else begin
            ped_meta <= ped_btn;
            ped_s    <= ped_meta;
            ped_d    <= ped_s;
        end
    end

    assign ped_rise    = ped_s & ~ped_d;
    assign enter_serve = (next_state == SERVE) && (state != SERVE);

    // Clear takes priority over set: a press landing on the same edge that
    // green is granted is already being served, so it must not re-request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_pend <= 1'b0;
        end else if (enter_serve) begin
            ped_pend <= 1'b0;
        end else if (ped_rise) begin
            ped_pend <= 1'b1;
        end
    end

    // State register. Because c is decoded straight from this register, the
    // asynchronous reset drops the request immediately, even mid-green.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Losing fg always returns to IDLE; if demand is still
    // present IDLE simply re-requests on the following cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (car_db || ped_pend) next_state = REQ;
            end
            REQ: begin
                if (fg)                        next_state = SERVE;
                else if (!car_db && !ped_pend) next_state = IDLE;
            end
            SERVE: begin
                if (!fg)          next_state = IDLE;
                else if (!car_db) next_state = DRAIN;
            end
            DRAIN: begin
                if (!fg)                next_state = IDLE;
                else if (car_db)        next_state = SERVE;
                else if (hold_cnt == '0) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Drain hold counter: loaded on the SERVE to DRAIN edge and counted down
    // only while DRAIN persists, so it stops at zero and never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (state == SERVE && next_state == DRAIN) begin
            hold_cnt <= CNT_W'(HOLD_CYC - 1);
        end else if (state == DRAIN && next_state == DRAIN) begin
            hold_cnt <= hold_cnt - CNT_W'(1);
        end
    end

    // Moore output: any state other than IDLE is an outstanding request.
    always_comb begin
        c = 1'b0;
        if (state != IDLE) c = 1'b1;
    end

endmodule
